// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter: NREQ requesters share one FIFO write port.
// Optional FIFO_ARB_STATS_EN adds a saturating stall counter output (stall_cnt).
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic               fifo_wr,
  output logic [DW-1:0]      fifo_din,
  input  logic               fifo_full
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] C_BMAX     = CW'(BURST_MAX);
  localparam logic [OW-1:0] C_LAST_RST = OW'(NREQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          r_state, w_state_nxt;
  logic [OW-1:0]   r_owner, w_owner_nxt;
  logic [OW-1:0]   r_last, w_last_nxt;
  logic [OW-1:0]   w_pick, w_cand;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            w_found, w_req_own, w_beat;
  logic [DW-1:0]   w_data [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_data[i] = req_data[i*DW +: DW];
    end
  end

  // Search starts one past the last owner and wraps, so the first hit is the fair winner
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_cand = OW'((32'(r_last) + i) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_req_own = req[r_owner];
  assign w_beat    = (r_state == BURST) && w_req_own && !fifo_full;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BURST;
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (!w_req_own) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end else if (!fifo_full) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_cnt_nxt == C_BMAX) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_owner;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_gnt_nxt = '0;
    if (w_state_nxt == BURST) w_gnt_nxt[w_owner_nxt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= C_LAST_RST;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  always_comb begin
    ack          = '0;
    ack[r_owner] = w_beat;
  end

  assign gnt      = r_gnt;
  assign fifo_wr  = w_beat;
  assign fifo_din = w_beat ? w_data[r_owner] : '0;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if ((r_state == BURST) && w_req_own && fifo_full && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DW=8, BURST_MAX=4).
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int BM   = 4;

  logic        clk, rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt, ack;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic        fifo_full;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks, failures;
  logic [7:0] dat [4];

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_full(fifo_full)
`ifdef FIFO_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pack();
    req_data = {dat[3], dat[2], dat[1], dat[0]};
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    pack();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Move to just after the next rising edge; requesters present their next beat if acked.
  task automatic next_cycle(input logic [3:0] a);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) if (a[i]) dat[i] = dat[i] + 8'd1;
    pack();
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111; fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = 8'h55;
    pack();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt k=%0d got=%b exp=0000", k, gnt); end
      checks++; if (ack !== 4'b0) begin failures++; $display("FAIL reset_ack k=%0d got=%b exp=0000", k, ack); end
      checks++; if (fifo_wr !== 1'b0) begin failures++; $display("FAIL reset_wr k=%0d got=%b exp=0", k, fifo_wr); end
      checks++; if (fifo_din !== 8'h00) begin failures++; $display("FAIL reset_din k=%0d got=%h exp=00", k, fifo_din); end
`ifdef FIFO_ARB_STATS_EN
      checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_stall k=%0d got=%h exp=0", k, stall_cnt); end
`endif
    end
  endtask

  task automatic test_single();
    logic [3:0] eg [8] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1};
    logic [7:0] ed [8] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'hA4, 8'hA5};
    logic [3:0] a;
    do_reset();
    dat[0] = 8'hA0; pack(); req = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a = ack;
      checks++; if (gnt !== eg[k]) begin failures++; $display("FAIL single_gnt k=%0d got=%b exp=%b", k, gnt, eg[k]); end
      checks++; if (fifo_wr !== (ed[k] != 8'h00)) begin failures++; $display("FAIL single_wr k=%0d got=%b exp=%b", k, fifo_wr, (ed[k] != 8'h00)); end
      checks++; if (fifo_din !== ed[k]) begin failures++; $display("FAIL single_din k=%0d got=%h exp=%h", k, fifo_din, ed[k]); end
      checks++; if (ack !== ((ed[k] != 8'h00) ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL single_ack k=%0d got=%b", k, ack); end
      next_cycle(a);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001 || fifo_wr !== 1'b0) begin failures++; $display("FAIL single_drop gnt=%b wr=%b exp gnt=0001 wr=0", gnt, fifo_wr); end
    next_cycle(4'b0);
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_idle got=%b exp=0000", gnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] a, eg;
    logic [7:0] ed;
    logic       ew;
    int         burst, own, pos;
    do_reset();
    for (int i = 0; i < 4; i++) dat[i] = 8'(8'h10 * (i + 1));
    pack(); req = 4'b1111;
    for (int k = 0; k < 25; k++) begin
      eg = '0; ed = '0; ew = 1'b0;
      if (k > 0 && ((k - 1) % 5) != 4) begin
        burst = (k - 1) / 5; pos = (k - 1) % 5; own = burst % 4;
        eg = 4'(1 << own);
        ed = 8'(8'h10 * (own + 1) + (burst / 4) * 4 + pos);
        ew = 1'b1;
      end
      @(negedge clk);
      a = ack;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, eg); end
      checks++; if (fifo_wr !== ew) begin failures++; $display("FAIL rr_wr k=%0d got=%b exp=%b", k, fifo_wr, ew); end
      checks++; if (fifo_din !== ed) begin failures++; $display("FAIL rr_din k=%0d got=%h exp=%h", k, fifo_din, ed); end
      checks++; if (ack !== (ew ? eg : 4'b0)) begin failures++; $display("FAIL rr_ack k=%0d got=%b exp=%b", k, ack, (ew ? eg : 4'b0)); end
      next_cycle(a);
    end
  endtask

  task automatic test_stall();
    logic [3:0] a, eg;
    logic [7:0] ed;
    logic       ew;
    do_reset();
    dat[2] = 8'hC0; pack(); req = 4'b0100;
    for (int k = 0; k < 11; k++) begin
      fifo_full = (k >= 3 && k <= 7);
      eg = (k >= 1 && k <= 9) ? 4'b0100 : 4'b0000;
      ew = (k == 1 || k == 2 || k == 8 || k == 9);
      ed = (k == 1) ? 8'hC0 : (k == 2) ? 8'hC1 : (k == 8) ? 8'hC2 : (k == 9) ? 8'hC3 : 8'h00;
      @(negedge clk);
      a = ack;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL stall_gnt k=%0d got=%b exp=%b", k, gnt, eg); end
      checks++; if (fifo_wr !== ew) begin failures++; $display("FAIL stall_wr k=%0d got=%b exp=%b", k, fifo_wr, ew); end
      checks++; if (fifo_din !== ed) begin failures++; $display("FAIL stall_din k=%0d got=%h exp=%h", k, fifo_din, ed); end
      checks++; if (ack !== (ew ? 4'b0100 : 4'b0)) begin failures++; $display("FAIL stall_ack k=%0d got=%b", k, ack); end
`ifdef FIFO_ARB_STATS_EN
      if (k == 2 || k == 8 || k == 10) begin
        checks++;
        if (stall_cnt !== ((k == 2) ? 16'd0 : 16'd5)) begin
          failures++; $display("FAIL stall_cnt k=%0d got=%0d exp=%0d", k, stall_cnt, (k == 2) ? 0 : 5);
        end
      end
`endif
      next_cycle(a);
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_drop();
    logic [3:0] eg [5] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h8};
    logic [7:0] ed [5] = '{8'h00, 8'hD0, 8'h00, 8'h00, 8'hE0};
    logic [3:0] a;
    do_reset();
    dat[1] = 8'hD0; dat[3] = 8'hE0; pack();
    for (int k = 0; k < 5; k++) begin
      req = (k >= 2) ? 4'b1000 : 4'b1010;
      @(negedge clk);
      a = ack;
      checks++; if (gnt !== eg[k]) begin failures++; $display("FAIL drop_gnt k=%0d got=%b exp=%b", k, gnt, eg[k]); end
      checks++; if (fifo_wr !== (ed[k] != 8'h00)) begin failures++; $display("FAIL drop_wr k=%0d got=%b exp=%b", k, fifo_wr, (ed[k] != 8'h00)); end
      checks++; if (fifo_din !== ed[k]) begin failures++; $display("FAIL drop_din k=%0d got=%h exp=%h", k, fifo_din, ed[k]); end
      next_cycle(a);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    dat[0] = 8'hB0; dat[3] = 8'hB8; pack(); req = 4'b0001;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL async_pre_gnt got=%b exp=0000", gnt); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001 || fifo_wr !== 1'b1 || fifo_din !== 8'hB0) begin
      failures++; $display("FAIL async_burst gnt=%b wr=%b din=%h exp 0001/1/b0", gnt, fifo_wr, fifo_din);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL async_gnt got=%b exp=0000", gnt); end
    checks++; if (fifo_wr !== 1'b0 || ack !== 4'b0000 || fifo_din !== 8'h00) begin
      failures++; $display("FAIL async_wr wr=%b ack=%b din=%h exp 0/0000/00", fifo_wr, ack, fifo_din);
    end
    req = 4'b1001;
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL async_regrant got=%b exp=0001", gnt); end
    checks++; if (fifo_wr !== 1'b1 || fifo_din !== 8'hB0) begin
      failures++; $display("FAIL async_rewrite wr=%b din=%h exp 1/b0", fifo_wr, fifo_din);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; req = '0; fifo_full = 1'b0; req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
